// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared state type, default geometry and coordinate width helpers
package gauss_pkg;

    localparam int GAUSS_IMG_W = 160;
    localparam int GAUSS_IMG_H = 120;
    localparam int GAUSS_KSIZE = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } gauss_state_e;

    function automatic int col_w(input int img_w);
        return (img_w > 1) ? $clog2(img_w) : 1;
    endfunction

    function automatic int row_w(input int img_h);
        return (img_h > 1) ? $clog2(img_h) : 1;
    endfunction

endpackage

// File: rtl/gauss_pos_cnt.sv
// rtl/gauss_pos_cnt.sv - wrapping col/row position counter; clear+inc together restarts at (row 0, col 1)
module gauss_pos_cnt
    import gauss_pkg::*;
#(
    parameter int IMG_W = GAUSS_IMG_W,
    parameter int IMG_H = GAUSS_IMG_H,
    localparam int CW = col_w(IMG_W),
    localparam int RW = row_w(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last_col,
    output logic          last_pix
);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            // The pixel accepted alongside a clear is (0,0); the counter points at the next one.
            col_d = inc ? CW'(1) : '0;
            row_d = '0;
        end else if (inc) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col      = col_q;
    assign row      = row_q;
    assign last_col = (col_q == COL_MAX);
    assign last_pix = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/gauss_win_ctrl.sv
// rtl/gauss_win_ctrl.sv - Gaussian window controller; GAUSS_WIN_BACKPRESSURE_EN enables m_ready backpressure
module gauss_win_ctrl
    import gauss_pkg::*;
#(
    parameter int IMG_W = GAUSS_IMG_W,
    parameter int IMG_H = GAUSS_IMG_H,
    parameter int KSIZE = GAUSS_KSIZE,
    localparam int CW = col_w(IMG_W),
    localparam int RW = row_w(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic          s_sof,
    input  logic          m_ready,
    output logic          s_ready,
    output logic          lb_shift_en,
    output logic          win_valid,
    output logic [CW-1:0] ctr_col,
    output logic [RW-1:0] ctr_row,
    output logic          eof,
    output logic          sof_err
);

    localparam int            HALF          = (KSIZE - 1) / 2;
    localparam logic [CW-1:0] HALF_C        = CW'(HALF);
    localparam logic [RW-1:0] HALF_R        = RW'(HALF);
    localparam logic [CW-1:0] WIN_COL_MIN   = CW'(KSIZE - 1);
    localparam logic [RW-1:0] WIN_ROW_MIN   = RW'(KSIZE - 1);
    localparam logic [RW-1:0] FILL_ROW_LAST = RW'(KSIZE - 2);

    gauss_state_e state_q, state_d;

    logic          win_valid_q, win_valid_d;
    logic          eof_q, eof_d;
    logic          sof_err_q, sof_err_d;
    logic [CW-1:0] ctr_col_q, ctr_col_d;
    logic [RW-1:0] ctr_row_q, ctr_row_d;

    logic          acc;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          win_hit;
    logic          last_hit;
    logic          ready_base;
    logic          out_en;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_col;
    logic          last_pix;

`ifdef GAUSS_WIN_BACKPRESSURE_EN
    assign ready_base = m_ready;
    assign out_en     = m_ready;
`else
    logic m_ready_unused;
    assign m_ready_unused = m_ready;
    assign ready_base     = 1'b1;
    assign out_en         = 1'b1;
`endif

    gauss_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clr),
        .inc      (cnt_inc),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    always_comb begin
        state_d     = state_q;
        s_ready     = 1'b0;
        lb_shift_en = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        win_hit     = 1'b0;
        last_hit    = 1'b0;
        sof_err_d   = sof_err_q;

        if (state_q != DONE) begin
            s_ready = ready_base & ~rst;
        end
        acc = s_valid & s_ready;

        case (state_q)
            IDLE: begin
                // Pixels without s_sof are consumed but never reach the line buffers.
                if (acc && s_sof) begin
                    state_d     = FILL;
                    cnt_clr     = 1'b1;
                    cnt_inc     = 1'b1;
                    lb_shift_en = 1'b1;
                end
            end
            FILL, RUN: begin
                if (acc) begin
                    lb_shift_en = 1'b1;
                    if (s_sof) begin
                        sof_err_d = 1'b1;
                        state_d   = FILL;
                        cnt_clr   = 1'b1;
                        cnt_inc   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        win_hit = (row >= WIN_ROW_MIN) && (col >= WIN_COL_MIN);
                        if (last_pix) begin
                            state_d  = DONE;
                            last_hit = 1'b1;
                        end else if ((state_q == FILL) && (row == FILL_ROW_LAST) && last_col) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Window outputs only advance when downstream can take them.
    always_comb begin
        win_valid_d = win_valid_q;
        eof_d       = eof_q;
        ctr_col_d   = ctr_col_q;
        ctr_row_d   = ctr_row_q;
        if (out_en) begin
            win_valid_d = win_hit;
            eof_d       = win_hit & last_hit;
            if (win_hit) begin
                ctr_col_d = col - HALF_C;
                ctr_row_d = row - HALF_R;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_valid_q <= 1'b0;
            eof_q       <= 1'b0;
            sof_err_q   <= 1'b0;
            ctr_col_q   <= '0;
            ctr_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            eof_q       <= eof_d;
            sof_err_q   <= sof_err_d;
            ctr_col_q   <= ctr_col_d;
            ctr_row_q   <= ctr_row_d;
        end
    end

    assign win_valid = win_valid_q;
    assign eof       = eof_q;
    assign sof_err   = sof_err_q;
    assign ctr_col   = ctr_col_q;
    assign ctr_row   = ctr_row_q;

endmodule

// File: tb/tb_gauss_win_ctrl.sv
// tb/tb_gauss_win_ctrl.sv - directed self-checking bench for gauss_win_ctrl at 8x6, kernel 5
module tb_gauss_win_ctrl;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int KSIZE = 5;
`ifdef GAUSS_WIN_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    localparam int FIRST_CTR = 2 * 256 + 2;
    localparam int LAST_CTR  = 3 * 256 + 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_sof;
    logic       m_ready;
    logic       s_ready;
    logic       lb_shift_en;
    logic       win_valid;
    logic [2:0] ctr_col;
    logic [2:0] ctr_row;
    logic       eof;
    logic       sof_err;

    gauss_win_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .KSIZE (KSIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_sof       (s_sof),
        .m_ready     (m_ready),
        .s_ready     (s_ready),
        .lb_shift_en (lb_shift_en),
        .win_valid   (win_valid),
        .ctr_col     (ctr_col),
        .ctr_row     (ctr_row),
        .eof         (eof),
        .sof_err     (sof_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int shifts  = 0;
    int eof_cnt = 0;
    int eof_any = 0;
    int win_q[$];

    always @(negedge clk) begin
        if (lb_shift_en) shifts++;
        if (eof) eof_any++;
        if (win_valid && (m_ready || !BP)) begin
            win_q.push_back(int'(ctr_row) * 256 + int'(ctr_col));
            if (eof) eof_cnt++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input bit sof0, input bit toggle);
        int sent = 0;
        int cyc  = 0;
        while (sent < n) begin
            s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            s_sof   = sof0 && (sent == 0) && s_valid;
            cycle();
            if (s_valid) sent++;
            cyc++;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic frame_check(input string tag, input int w0, input int e0, input int s0,
                               input int exp_shifts);
        int n;
        int first_c;
        int last_c;
        n       = win_q.size() - w0;
        first_c = (n > 0) ? win_q[w0] : -1;
        last_c  = (n > 0) ? win_q[win_q.size() - 1] : -1;
        check({tag, "_wins"}, n, 8);
        check({tag, "_first_ctr"}, first_c, FIRST_CTR);
        check({tag, "_last_ctr"}, last_c, LAST_CTR);
        check({tag, "_eof"}, eof_cnt - e0, 1);
        check({tag, "_shifts"}, shifts - s0, exp_shifts);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int w0, e0, s0, a0;
        rst     = 1'b1;
        s_valid = 1'b1;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        cycle();
        cycle();
        check("rst_s_ready", s_ready, 0);
        check("rst_shift", lb_shift_en, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_eof", eof, 0);
        check("rst_sof_err", sof_err, 0);
        check("rst_ctr", int'(ctr_row) * 256 + int'(ctr_col), 0);

        rst     = 1'b0;
        s_valid = 1'b0;
        cycle();
        check("idle_ready", s_ready, 1);

        // pixels with no sof in IDLE
        w0 = win_q.size(); s0 = shifts;
        s_valid = 1'b1;
        s_sof   = 1'b0;
        repeat (10) cycle();
        s_valid = 1'b0;
        cycle();
        check("nosof_shifts", shifts - s0, 0);
        check("nosof_wins", win_q.size() - w0, 0);
        check("nosof_ctr", int'(ctr_row) * 256 + int'(ctr_col), 0);

        // full frame, continuous valid
        w0 = win_q.size(); e0 = eof_cnt; s0 = shifts;
        feed(48, 1'b1, 1'b0);
        check("full_done_ready", s_ready, 0);
        check("full_last_wv", win_valid, 1);
        check("full_last_eof", eof, 1);
        cycle();
        check("full_wv_drop", win_valid, 0);
        check("full_eof_drop", eof, 0);
        check("full_idle_ready", s_ready, 1);
        frame_check("full", w0, e0, s0, 48);

        // valid toggling 1/0: 96 cycles per frame
        w0 = win_q.size(); e0 = eof_cnt; s0 = shifts;
        feed(48, 1'b1, 1'b1);
        check("tog_done_ready", s_ready, 0);
        cycle();
        check("tog_idle_ready", s_ready, 1);
        frame_check("tog", w0, e0, s0, 48);

        // sof at pixel 20 restarts the frame
        w0 = win_q.size(); e0 = eof_cnt; s0 = shifts;
        feed(20, 1'b1, 1'b0);
        check("mid_sof_err_before", sof_err, 0);
        feed(1, 1'b1, 1'b0);
        check("mid_sof_err_set", sof_err, 1);
        feed(47, 1'b0, 1'b0);
        cycle();
        frame_check("restart", w0, e0, s0, 68);
        check("sof_err_sticky", sof_err, 1);

`ifdef GAUSS_WIN_BACKPRESSURE_EN
        begin
            int sent = 0;
            int hold = 0;
            int held = 0;
            bit first_seen = 1'b0;
            w0 = win_q.size(); e0 = eof_cnt; s0 = shifts;
            for (int cyc = 0; cyc < 300 && sent < 48; cyc++) begin
                s_valid = 1'b1;
                s_sof   = (sent == 0);
                m_ready = (hold == 0);
                #1;
                if (lb_shift_en) sent++;
                if (hold > 0) begin
                    check("bp_noacc", lb_shift_en, 0);
                    hold--;
                end
                @(posedge clk);
                #1;
                if (win_valid && !first_seen) begin
                    first_seen = 1'b1;
                    hold = 3;
                end
                if (win_valid && ctr_row == 3'd2 && ctr_col == 3'd2) held++;
            end
            s_valid = 1'b0;
            s_sof   = 1'b0;
            m_ready = 1'b1;
            check("bp_sent", sent, 48);
            cycle();
            check("bp_held", held, 4);
            frame_check("bp", w0, e0, s0, 48);
        end
`else
        // m_ready is ignored without backpressure
        m_ready = 1'b0;
        w0 = win_q.size(); e0 = eof_cnt; s0 = shifts;
        feed(48, 1'b1, 1'b0);
        cycle();
        frame_check("mready_ign", w0, e0, s0, 48);
        m_ready = 1'b1;
`endif

        // reset in RUN at row 4
        w0 = win_q.size(); a0 = eof_any;
        feed(38, 1'b1, 1'b0);
        rst     = 1'b1;
        s_valid = 1'b1;
        cycle();
        check("rrun_s_ready", s_ready, 0);
        check("rrun_shift", lb_shift_en, 0);
        check("rrun_win_valid", win_valid, 0);
        check("rrun_eof", eof, 0);
        check("rrun_sof_err", sof_err, 0);
        check("rrun_ctr", int'(ctr_row) * 256 + int'(ctr_col), 0);
        rst   = 1'b0;
        s_sof = 1'b0;
        #1;
        check("rrun_idle_ready", s_ready, 1);
        check("rrun_idle_drop", lb_shift_en, 0);
        s_valid = 1'b0;
        repeat (3) cycle();
        check("rrun_wins", win_q.size() - w0, 2);
        check("rrun_no_eof", eof_any - a0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gauss_win_ctrl.md
GAUSS_WIN_CTRL -- requirements
Module: gauss_win_ctrl

Interface
REQ-001 Parameter IMG_W, default 160, active pixels per row.
REQ-002 Parameter IMG_H, default 120, rows per frame.
REQ-003 Parameter KSIZE, default 5, odd Gaussian kernel size (3..7); the line-buffer chain holds KSIZE-1 rows.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 s_valid  in  1  input pixel valid.
REQ-007 s_sof  in  1  start of frame, qualifies the first pixel of a frame.
REQ-008 m_ready  in  1  downstream ready.
REQ-009 s_ready  out  1  controller accepts a pixel this cycle.
REQ-010 lb_shift_en  out  1  shift strobe to the line-buffer chain and the window registers.
REQ-011 win_valid  out  1  full KSIZE x KSIZE window valid.
REQ-012 ctr_col, ctr_row  out  clog2(IMG_W), clog2(IMG_H)  window-centre coordinates.
REQ-013 eof  out  1  one-cycle pulse with the last window of the frame.
REQ-014 sof_err  out  1  sticky; s_sof seen mid-frame.

Function
REQ-015 A pixel SHALL be accepted (acc) when s_valid and s_ready are both high.
REQ-016 lb_shift_en SHALL equal acc, combinationally.
REQ-017 The FSM SHALL have four states: IDLE, FILL, RUN, DONE.
REQ-018 IDLE: s_ready=1. acc with s_sof -> FILL, col=1, row=0. acc without s_sof is dropped and the counters do not move.
REQ-019 col SHALL increment per acc and wrap IMG_W-1 -> 0 while incrementing row.
REQ-020 FILL -> RUN on the acc that makes row = KSIZE-1, col = 0.
REQ-021 win_valid SHALL be registered, asserting one cycle after an acc at (r, c) with r >= KSIZE-1 and c >= KSIZE-1.
REQ-022 ctr_row SHALL be r-(KSIZE-1)/2 and ctr_col SHALL be c-(KSIZE-1)/2, registered with win_valid.
REQ-023 The acc at (IMG_H-1, IMG_W-1) -> DONE; eof pulses together with that win_valid.
REQ-024 DONE SHALL last exactly one cycle with s_ready=0, then -> IDLE with counters cleared.
REQ-025 s_sof on an acc in FILL/RUN SHALL set sof_err and restart FILL at col=1, row=0; the partial frame is abandoned and emits no eof.
REQ-026 s_valid low SHALL freeze counters and state; win_valid drops the next cycle.
REQ-027 Output reset values: s_ready=0 during reset; win_valid=0, eof=0, sof_err=0, ctr_col=0, ctr_row=0, lb_shift_en=0.

Reset
REQ-028 rst SHALL return the FSM to IDLE and apply the values of REQ-027 on the next edge, from any state.
REQ-029 A frame in progress when rst asserts SHALL be abandoned with no eof; line-buffer contents are don't-care.
REQ-030 sof_err SHALL clear only on rst.

Configuration
REQ-031 Macro GAUSS_WIN_BACKPRESSURE_EN defined: s_ready = m_ready in IDLE/FILL/RUN.
REQ-032 Macro GAUSS_WIN_BACKPRESSURE_EN defined: win_valid, ctr_* and eof SHALL hold stable while m_ready=0.
REQ-033 Macro undefined: m_ready SHALL be ignored and s_ready=1 in IDLE/FILL/RUN.
REQ-034 Macro undefined: win_valid SHALL be a pure one-cycle-per-acc strobe.

Structure
REQ-035 Package gauss_pkg SHALL hold the state enum type, the default IMG_W/IMG_H/KSIZE constants and the coordinate width functions.
REQ-036 One sub-module, gauss_pos_cnt, SHALL implement the wrapping col/row counter with inc, clear and last-pixel outputs.

Verification (IMG_W=8, IMG_H=6, KSIZE=5)
REQ-037 Full frame, s_valid always 1 -> 8 win_valid pulses; first ctr=(2,2), last ctr=(3,5) with eof; 48 lb_shift_en pulses.
REQ-038 Pixels with no s_sof in IDLE -> no shift, no win_valid, counters stay 0.
REQ-039 s_sof at pixel 20 of a frame -> sof_err=1, counters restart, and a following full frame still gives 8 windows.
REQ-040 rst asserted in RUN at row 4 -> next cycle IDLE, all outputs 0, no eof.
REQ-041 BACKPRESSURE_EN, m_ready low 3 cycles at the first window -> ctr=(2,2) held 4 cycles, no acc, 8 windows total.
REQ-042 s_valid toggling 1/0 -> frame takes 96 cycles and windows match REQ-037.
